// File: rtl/exibidor_pkg.sv
// +----------------------------------------------------------------------+
// | exibidor_pkg                                                         |
// | Shared FSM encoding, 7-segment patterns and double-dabble step.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package exibidor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_LOAD = 2'd2
  } state_t;

  localparam int c_num_digits = 4;
  localparam int c_dd_iters   = 8;

  // Active-low {g,f,e,d,c,b,a}
  localparam logic [6:0] c_seg_blank = 7'b1111111;
  localparam logic [6:0] c_seg_minus = 7'b0111111;
  localparam logic [9:0][6:0] c_seg_digits = {
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  // One shift-and-add-3 iteration on {hundreds, tens, units, binary[7:0]}.
  function automatic logic [19:0] dd_step(input logic [19:0] v);
    logic [19:0] t;
    t = v;
    if (t[19:16] >= 4'd5) t[19:16] = t[19:16] + 4'd3;
    if (t[15:12] >= 4'd5) t[15:12] = t[15:12] + 4'd3;
    if (t[11:8]  >= 4'd5) t[11:8]  = t[11:8]  + 4'd3;
    return {t[18:0], 1'b0};
  endfunction

endpackage

`default_nettype wire

// File: rtl/decod_7seg.sv
// +----------------------------------------------------------------------+
// | decod_7seg                                                           |
// | BCD digit to active-low 7-segment pattern with blank/minus selects.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module decod_7seg
  import exibidor_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  input  logic       minus,
  output logic [6:0] seg
);

  always_comb begin
    seg = c_seg_blank;
    if (blank) begin
      seg = c_seg_blank;
    end else if (minus) begin
      seg = c_seg_minus;
    end else if (bcd <= 4'd9) begin
      seg = c_seg_digits[bcd];
    end
  end

endmodule

`default_nettype wire

// File: rtl/exibidor_resultado.sv
// +----------------------------------------------------------------------+
// | exibidor_resultado                                                   |
// | Captures the ALU result, converts it to BCD and scans 4 digits.      |
// | Build option: SIGNED_DISPLAY_EN shows two's-complement with sign.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module exibidor_resultado
  import exibidor_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [8:0] Q_in,
  input  logic       load,
  output logic       busy,
  output logic       done,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       ovf_led
);

  localparam int c_cnt_w = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(SCAN_DIV - 1);
  localparam logic [2:0] c_iter_last = 3'(c_dd_iters - 1);

  state_t r_state;
  state_t w_state_next;

  logic [2:0]  r_iter;
  logic [19:0] r_shift;
  logic        r_neg;
  logic        r_ovf;
  logic        w_neg;
  logic [7:0]  w_mag;

  logic [3:0]  r_disp_h;
  logic [3:0]  r_disp_t;
  logic [3:0]  r_disp_u;
  logic        r_disp_neg;
  logic        r_disp_ovf;
  logic        r_disp_valid;
  logic        r_done;

  logic [c_cnt_w-1:0] r_scan_cnt;
  logic [1:0]         r_slot;
  logic               r_active;

  logic [3:0] w_bcd;
  logic       w_blank;
  logic       w_minus;

  always_comb begin
`ifdef SIGNED_DISPLAY_EN
    w_neg = Q_in[7];
    w_mag = Q_in[7] ? (~Q_in[7:0] + 8'd1) : Q_in[7:0];
`else
    w_neg = 1'b0;
    w_mag = Q_in[7:0];
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (load) w_state_next = ST_CONV;
      ST_CONV: if (r_iter == c_iter_last) w_state_next = ST_LOAD;
      ST_LOAD: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_iter       <= '0;
      r_shift      <= '0;
      r_neg        <= 1'b0;
      r_ovf        <= 1'b0;
      r_disp_h     <= '0;
      r_disp_t     <= '0;
      r_disp_u     <= '0;
      r_disp_neg   <= 1'b0;
      r_disp_ovf   <= 1'b0;
      r_disp_valid <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (load) begin
            r_shift <= {12'd0, w_mag};
            r_neg   <= w_neg;
            r_ovf   <= Q_in[8];
            r_iter  <= '0;
          end
        end
        ST_CONV: begin
          r_shift <= dd_step(r_shift);
          r_iter  <= r_iter + 3'd1;
        end
        ST_LOAD: begin
          r_disp_h     <= r_shift[19:16];
          r_disp_t     <= r_shift[15:12];
          r_disp_u     <= r_shift[11:8];
          r_disp_neg   <= r_neg;
          r_disp_ovf   <= r_ovf;
          r_disp_valid <= 1'b1;
          r_done       <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Scanning starts on the first edge after reset so an stays all-off during reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scan_cnt <= '0;
      r_slot     <= '0;
      r_active   <= 1'b0;
    end else if (!r_active) begin
      r_active <= 1'b1;
    end else if (r_scan_cnt == c_cnt_last) begin
      r_scan_cnt <= '0;
      r_slot     <= r_slot + 2'd1;
    end else begin
      r_scan_cnt <= r_scan_cnt + 1'b1;
    end
  end

  always_comb begin
    w_bcd   = 4'd0;
    w_blank = 1'b1;
    w_minus = 1'b0;
    if (r_active && r_disp_valid) begin
      case (r_slot)
        2'd0: begin
          w_bcd   = r_disp_u;
          w_blank = 1'b0;
        end
        2'd1: begin
          w_bcd   = r_disp_t;
          w_blank = (r_disp_h == 4'd0) && (r_disp_t == 4'd0);
        end
        2'd2: begin
          w_bcd   = r_disp_h;
          w_blank = (r_disp_h == 4'd0);
        end
        default: begin
          w_minus = r_disp_neg;
          w_blank = !r_disp_neg;
        end
      endcase
    end
  end

  always_comb begin
    an = 4'b1111;
    if (r_active) an[r_slot] = 1'b0;
  end

  decod_7seg u_decod (
    .bcd   (w_bcd),
    .blank (w_blank),
    .minus (w_minus),
    .seg   (seg)
  );

  assign busy    = (r_state != ST_IDLE);
  assign done    = r_done;
  assign ovf_led = r_disp_ovf;

endmodule

`default_nettype wire

// File: tb/tb_exibidor_resultado.sv
// Self-checking bench for exibidor_resultado: randomized loads against an arithmetic display model.
`default_nettype none

module tb_exibidor_resultado;

  localparam int SCAN_DIV = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [8:0] Q_in;
  logic       load;
  logic       busy;
  logic       done;
  logic [6:0] seg;
  logic [3:0] an;
  logic       ovf_led;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  exibidor_resultado #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk     (clk),
    .rst     (rst),
    .Q_in    (Q_in),
    .load    (load),
    .busy    (busy),
    .done    (done),
    .seg     (seg),
    .an      (an),
    .ovf_led (ovf_led)
  );

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [6:0] digit_pat(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Expected segments for a slot, straight from decimal arithmetic.
  function automatic logic [6:0] model_seg(input logic [8:0] q, input int slot, input bit valid);
    int v, h, t, u;
    bit neg;
    v   = int'(q[7:0]);
    neg = 1'b0;
    if (!valid) return 7'b1111111;
`ifdef SIGNED_DISPLAY_EN
    if (v >= 128) begin
      neg = 1'b1;
      v   = 256 - v;
    end
`endif
    h = v / 100;
    t = (v / 10) % 10;
    u = v % 10;
    case (slot)
      0: return digit_pat(u);
      1: return (h == 0 && t == 0) ? 7'b1111111 : digit_pat(t);
      2: return (h == 0) ? 7'b1111111 : digit_pat(h);
      default: return neg ? 7'b0111111 : 7'b1111111;
    endcase
  endfunction

  // Samples seg while each digit slot is enabled; ok=0 if a slot never appears.
  task automatic capture_display(output logic [3:0][6:0] s, output bit ok);
    logic [3:0] exp_an;
    ok = 1'b1;
    s  = '1;
    for (int k = 0; k < 4; k++) begin
      int w;
      w      = 0;
      exp_an = ~(4'b0001 << k);
      while (an !== exp_an && w < 40) begin
        tick();
        w++;
      end
      if (w >= 40) ok = 1'b0;
      else s[k] = seg;
    end
  endtask

  task automatic start_load(input logic [8:0] q);
    Q_in = q;
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic test_reset;
    rst  = 1'b1;
    load = 1'b0;
    Q_in = '0;
    tick(3);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || ovf_led !== 1'b0 || seg !== 7'b1111111 || an !== 4'b1111) begin
      n_errors++;
      $display("FAIL reset_state got busy=%b done=%b ovf=%b seg=%b an=%b want 0 0 0 1111111 1111",
               busy, done, ovf_led, seg, an);
    end
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      logic [3:0] exp_an;
      tick();
      exp_an = ~(4'b0001 << ((c / SCAN_DIV) % 4));
      n_checks++;
      if (an !== exp_an || seg !== 7'b1111111) begin
        n_errors++;
        $display("FAIL scan cycle %0d got an=%b seg=%b want an=%b seg=1111111", c, an, seg, exp_an);
      end
    end
  endtask

  task automatic test_timing;
    logic [8:0] q;
    logic [3:0][6:0] cap;
    bit ok;
    q = 9'h0FF;
    start_load(q);
    n_checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_errors++;
      $display("FAIL busy_after_k got busy=%b done=%b want 1 0", busy, done);
    end
    for (int i = 1; i <= 9; i++) begin
      tick();
      n_checks++;
      if (i < 9 && (busy !== 1'b1 || done !== 1'b0)) begin
        n_errors++;
        $display("FAIL conv_k+%0d got busy=%b done=%b want 1 0", i, busy, done);
      end else if (i == 9 && (busy !== 1'b0 || done !== 1'b1)) begin
        n_errors++;
        $display("FAIL done_k+9 got busy=%b done=%b want 0 1", busy, done);
      end
    end
    tick();
    n_checks++;
    if (done !== 1'b0) begin
      n_errors++;
      $display("FAIL done_width got done=%b want 0", done);
    end
    capture_display(cap, ok);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL timing_scan got timeout want all slots");
    end
    for (int s = 0; s < 4; s++) begin
      n_checks++;
      if (cap[s] !== model_seg(q, s, 1'b1)) begin
        n_errors++;
        $display("FAIL timing_digit slot%0d got %b want %b", s, cap[s], model_seg(q, s, 1'b1));
      end
    end
    n_checks++;
    if (ovf_led !== q[8]) begin
      n_errors++;
      $display("FAIL timing_ovf got %b want %b", ovf_led, q[8]);
    end
  endtask

  task automatic test_patterns;
    logic [8:0] list [12];
    logic [3:0][6:0] cap;
    bit ok;
    int lat;
    list[0] = 9'h107;
    list[1] = 9'h0F6;
    list[2] = 9'h000;
    list[3] = 9'h1FF;
    list[4] = 9'h064;
    list[5] = 9'h009;
    for (int j = 6; j < 12; j++) list[j] = 9'($urandom_range(0, 511));
    for (int j = 0; j < 12; j++) begin
      start_load(list[j]);
      lat = 0;
      while (done !== 1'b1 && lat < 20) begin
        tick();
        lat++;
      end
      n_checks++;
      if (lat != 9) begin
        n_errors++;
        $display("FAIL pattern_latency q=%h got %0d want 9", list[j], lat);
      end
      capture_display(cap, ok);
      n_checks++;
      if (!ok) begin
        n_errors++;
        $display("FAIL pattern_scan q=%h got timeout want all slots", list[j]);
      end
      for (int s = 0; s < 4; s++) begin
        n_checks++;
        if (cap[s] !== model_seg(list[j], s, 1'b1)) begin
          n_errors++;
          $display("FAIL pattern_digit q=%h slot%0d got %b want %b",
                   list[j], s, cap[s], model_seg(list[j], s, 1'b1));
        end
      end
      n_checks++;
      if (ovf_led !== list[j][8]) begin
        n_errors++;
        $display("FAIL pattern_ovf q=%h got %b want %b", list[j], ovf_led, list[j][8]);
      end
    end
  endtask

  task automatic test_ignore_busy;
    logic [3:0][6:0] cap;
    bit ok;
    int n_done;
    start_load(9'h080);
    tick(2);
    start_load(9'h012);
    n_done = 0;
    for (int i = 0; i < 20; i++) begin
      if (done === 1'b1) n_done++;
      tick();
    end
    n_checks++;
    if (n_done != 1) begin
      n_errors++;
      $display("FAIL ignore_done_count got %0d want 1", n_done);
    end
    capture_display(cap, ok);
    for (int s = 0; s < 4; s++) begin
      n_checks++;
      if (!ok || cap[s] !== model_seg(9'h080, s, 1'b1)) begin
        n_errors++;
        $display("FAIL ignore_digit slot%0d got %b want %b", s, cap[s], model_seg(9'h080, s, 1'b1));
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [8:0] q2;
    logic [3:0][6:0] cap;
    bit ok;
    int e, first, second;
    q2   = 9'($urandom_range(0, 511));
    Q_in = 9'h0F6;
    load = 1'b1;
    tick();
    Q_in   = q2;
    e      = 0;
    first  = -1;
    second = -1;
    while (second < 0 && e < 40) begin
      tick();
      e++;
      if (done === 1'b1) begin
        if (first < 0) first = e;
        else second = e;
      end
    end
    load = 1'b0;
    n_checks++;
    if (first != 9 || second != 19) begin
      n_errors++;
      $display("FAIL held_load got done at %0d,%0d want 9,19", first, second);
    end
    capture_display(cap, ok);
    for (int s = 0; s < 4; s++) begin
      n_checks++;
      if (!ok || cap[s] !== model_seg(q2, s, 1'b1)) begin
        n_errors++;
        $display("FAIL held_digit q=%h slot%0d got %b want %b", q2, s, cap[s], model_seg(q2, s, 1'b1));
      end
    end
  endtask

  task automatic test_reset_mid_conv;
    logic [3:0][6:0] cap;
    bit ok;
    int n_done;
    start_load(9'h1AA);
    tick(12);
    start_load(9'($urandom_range(0, 511)));
    tick(4);
    rst = 1'b1;
    #2;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || ovf_led !== 1'b0 || seg !== 7'b1111111 || an !== 4'b1111) begin
      n_errors++;
      $display("FAIL reset_async got busy=%b done=%b ovf=%b seg=%b an=%b want 0 0 0 1111111 1111",
               busy, done, ovf_led, seg, an);
    end
    tick(2);
    rst    = 1'b0;
    n_done = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (done === 1'b1) n_done++;
    end
    n_checks++;
    if (n_done != 0) begin
      n_errors++;
      $display("FAIL reset_no_done got %0d pulses want 0", n_done);
    end
    capture_display(cap, ok);
    for (int s = 0; s < 4; s++) begin
      n_checks++;
      if (!ok || cap[s] !== 7'b1111111) begin
        n_errors++;
        $display("FAIL reset_blank slot%0d got %b want 1111111", s, cap[s]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_timing();
    test_patterns();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid_conv();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/exibidor_resultado.md
EXIBIDOR_RESULTADO -- requirements
Module: exibidor_resultado

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, meaning clk cycles per display digit slot (minimum 2).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port Q_in, input, 9, result word {overflow, resultado[7:0]} from the ALU result register.
REQ-005 SHALL have port load, input, 1, request to capture Q_in and convert it for display.
REQ-006 SHALL have port busy, output, 1, high while a capture/conversion is in progress.
REQ-007 SHALL have port done, output, 1, one-cycle pulse when new digits reach the display.
REQ-008 SHALL have port seg, output, 7, active-low segments {g,f,e,d,c,b,a}.
REQ-009 SHALL have port an, output, 4, active-low digit enables: an[0] units, an[1] tens, an[2] hundreds, an[3] sign.
REQ-010 SHALL have port ovf_led, output, 1, overflow bit of the last displayed word.

Function
REQ-011 SHALL implement FSM IDLE -> CONV -> LOAD -> IDLE.
REQ-012 In IDLE, load=1 at edge k SHALL capture Q_in, set busy=1 after edge k and enter CONV.
REQ-013 CONV SHALL run exactly 8 double-dabble iterations (add 3 to any BCD nibble >=5, then shift) on edges k+1..k+8.
REQ-014 At edge k+9 (LOAD) SHALL copy hundreds/tens/units/sign/overflow to display registers, drive done=1 for that cycle only and busy=0, then return to IDLE.
REQ-015 load while busy SHALL be ignored; load held high in IDLE SHALL start a new capture on the next IDLE cycle.
REQ-016 Display registers SHALL change only in LOAD; ovf_led SHALL equal the displayed overflow bit.
REQ-017 Leading-zero blanking: hundreds blank when 0; tens blank when hundreds and tens are both 0; units always shown.
REQ-018 Scan counter SHALL count 0..SCAN_DIV-1 and, on wrap, advance the digit slot 0->1->2->3->0; exactly one an bit low at a time.
REQ-019 seg SHALL show digits 0-9 in standard patterns, blank 7'b1111111, minus 7'b0111111.

Reset
REQ-020 rst=1 SHALL immediately force: FSM IDLE, busy=0, done=0, ovf_led=0, display registers blank, scan counter and slot 0, seg=7'b1111111, an=4'b1111.
REQ-021 Reset during CONV SHALL discard the conversion; the first edge after release starts scanning at slot 0 with all digits blank.

Configuration
REQ-022 Macro SIGNED_DISPLAY_EN defined: resultado SHALL be treated as two's complement; if bit 7 is set, the magnitude (0x80 -> 128) is converted and the sign digit shows minus.
REQ-023 SIGNED_DISPLAY_EN undefined: resultado SHALL be unsigned 0..255 and the sign digit always blank.

Structure
REQ-024 Package exibidor_pkg SHALL hold FSM state encoding, 7-segment pattern constants (digits, blank, minus) and digit count 4.
REQ-025 Sub-module decod_7seg SHALL map a 4-bit BCD value plus blank/minus selects to seg.

Verification
REQ-026 Q_in=9'h0FF, load pulse -> done at k+9; digits 2,5,5; ovf_led=0 (unsigned build).
REQ-027 Q_in=9'h107 -> units 7, tens and hundreds blank, ovf_led=1.
REQ-028 Load 9'h080, then load 9'h012 at k+3 -> second ignored; unsigned shows 128; signed shows -128.
REQ-029 Q_in=9'h0F6 -> signed build shows -, blank, 1, 0; unsigned build shows 2,4,6.
REQ-030 SCAN_DIV=4 -> an steps 1110, 1101, 1011, 0111, 1110 every 4 cycles.
REQ-031 rst=1 at k+4 of a conversion -> busy=0, seg=7'b1111111, an=4'b1111 without waiting for an edge; no done pulse follows.
